// File: rtl/data_memory_pipelined.sv
// data_memory_pipelined
//   Byte-addressed data RAM for the load/store stage. Byte-lane write strobes, valid/ready
//   request port, registered read pipeline of RD_LAT (1 or 2) cycles, alignment and range
//   error reporting, and a clear sequencer that zeroes every word after reset.
//
// Parameters
//   ADDR_WIDTH  byte address width
//   DATA_WIDTH  word width in bits (16, 32 or 64)
//   MEM_DEPTH   number of words (power of 2, >= 4)
//   RD_LAT      cycles from acceptance to response (1 or 2)
//
// Ports
//   clk_in     clock, rising edge
//   rst_in     asynchronous active-high reset
//   req_valid  request present            req_ready  block accepts a request (RUN only)
//   req_wr     1 = store, 0 = load        req_addr   byte address
//   req_wdata  store data                 req_be     store byte enables, one per lane
//   rsp_valid  one pulse per accepted request
//   rsp_rdata  load data, zero for stores, errors and idle cycles
//   rsp_err    request was misaligned or out of range
module data_memory_pipelined #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned MEM_DEPTH  = 256,
   parameter int unsigned RD_LAT     = 1
) (
   input  logic                    clk_in,
   input  logic                    rst_in,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_wr,
   input  logic [ADDR_WIDTH-1:0]   req_addr,
   input  logic [DATA_WIDTH-1:0]   req_wdata,
   input  logic [DATA_WIDTH/8-1:0] req_be,
   output logic                    rsp_valid,
   output logic [DATA_WIDTH-1:0]   rsp_rdata,
   output logic                    rsp_err
);

   localparam int unsigned NB    = DATA_WIDTH / 8;
   localparam int unsigned LSB   = $clog2(NB);
   localparam int unsigned IDX_W = $clog2(MEM_DEPTH);

   typedef enum logic {StInit, StRun} state_e;

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   clr_cnt_q, clr_cnt_d;

   logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

   logic                  accept;
   logic [IDX_W-1:0]      idx;
   logic                  misaligned;
   logic                  out_of_range;
   logic                  err;
   logic [DATA_WIDTH-1:0] rd_word;

   logic                  mem_we;
   logic [IDX_W-1:0]      mem_waddr;
   logic [DATA_WIDTH-1:0] mem_wdata;

   logic                  s1_valid_q, s1_valid_d;
   logic                  s1_err_q, s1_err_d;
   logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d;

   // ---------------------------------------------------------------------------------------
   // Clear sequencer
   // ---------------------------------------------------------------------------------------
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q   <= StInit;
         clr_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      unique case (state_q)
         StInit: begin
            clr_cnt_d = clr_cnt_q + IDX_W'(1);
            if (clr_cnt_q == IDX_W'(MEM_DEPTH - 1)) begin
               state_d = StRun;
            end
         end
         StRun:   state_d = StRun;
         default: state_d = StInit;
      endcase
   end

   assign req_ready = (state_q == StRun);
   assign accept    = req_valid & req_ready;

   // ---------------------------------------------------------------------------------------
   // Address decode
   // ---------------------------------------------------------------------------------------
   assign idx        = req_addr[LSB+IDX_W-1:LSB];
   assign misaligned = |req_addr[LSB-1:0];

   if (ADDR_WIDTH > LSB + IDX_W) begin : g_range
      assign out_of_range = |req_addr[ADDR_WIDTH-1:LSB+IDX_W];
   end else begin : g_no_range
      assign out_of_range = 1'b0;
   end

   assign err     = misaligned | out_of_range;
   assign rd_word = mem_q[idx];

   // ---------------------------------------------------------------------------------------
   // Single write port: clear sequencer in INIT, lane-merged store in RUN
   // ---------------------------------------------------------------------------------------
   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = idx;
      mem_wdata = rd_word;
      if (state_q == StInit) begin
         mem_we    = 1'b1;
         mem_waddr = clr_cnt_q;
         mem_wdata = '0;
      end else if (accept && req_wr && !err) begin
         mem_we = |req_be;
         for (int unsigned i = 0; i < NB; i++) begin
            if (req_be[i]) begin
               mem_wdata[8*i +: 8] = req_wdata[8*i +: 8];
            end
         end
      end
   end

   // Storage has no reset; the sequencer zeroes it after every reset release.
   always_ff @(posedge clk_in) begin
      if (mem_we) begin
         mem_q[mem_waddr] <= mem_wdata;
      end
   end

   // ---------------------------------------------------------------------------------------
   // Response pipeline
   // ---------------------------------------------------------------------------------------
   always_comb begin
      s1_valid_d = accept;
      s1_err_d   = accept & err;
      s1_data_d  = '0;
      if (accept && !req_wr && !err) begin
         s1_data_d = rd_word;
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         s1_valid_q <= 1'b0;
         s1_err_q   <= 1'b0;
         s1_data_q  <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_err_q   <= s1_err_d;
         s1_data_q  <= s1_data_d;
      end
   end

   if (RD_LAT == 2) begin : g_lat2
      logic                  s2_valid_q, s2_valid_d;
      logic                  s2_err_q, s2_err_d;
      logic [DATA_WIDTH-1:0] s2_data_q, s2_data_d;

      always_comb begin
         s2_valid_d = s1_valid_q;
         s2_err_d   = s1_err_q;
         s2_data_d  = s1_data_q;
      end

      always_ff @(posedge clk_in or posedge rst_in) begin
         if (rst_in) begin
            s2_valid_q <= 1'b0;
            s2_err_q   <= 1'b0;
            s2_data_q  <= '0;
         end else begin
            s2_valid_q <= s2_valid_d;
            s2_err_q   <= s2_err_d;
            s2_data_q  <= s2_data_d;
         end
      end

      assign rsp_valid = s2_valid_q;
      assign rsp_err   = s2_err_q;
      assign rsp_rdata = s2_data_q;
   end else begin : g_lat1
      assign rsp_valid = s1_valid_q;
      assign rsp_err   = s1_err_q;
      assign rsp_rdata = s1_data_q;
   end

endmodule
